usb_serial_slip: RTL
====================

Name: usb_serial_slip

Overview:
- SLIP (RFC 1055) framing codec on the user side of the USB serial FIFO-PHY.
- The encoder takes user frames, escapes them, and writes the bytes into the PHY transmit FIFO.
- The decoder pops bytes from the PHY receive FIFO, removes the escapes, and hands delimited frames upstream with last and error flags.
- One clock domain; this is the same clock that drives the FIFO user-side ports.

Parameters:
- MAXLEN, 256: maximum decoded payload bytes per frame; power of 2, at least 2. A larger frame is an error.
- LEADEND, 1: when 1, the encoder emits an END byte before each frame as well as after it.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- tx_valid_i  in  1  user byte valid
- tx_data_i  in  8  user byte
- tx_last_i  in  1  byte is the last of its frame
- tx_ready_o  out  1  byte accepted when tx_valid_i && tx_ready_o
- fifo_tx_write_o  out  1  push into PHY transmit FIFO
- fifo_tx_data_o  out  8  byte pushed
- fifo_tx_full_i  in  1  PHY transmit FIFO full
- fifo_rx_read_o  out  1  pop from PHY receive FIFO
- fifo_rx_data_i  in  8  head byte, valid whenever !fifo_rx_empty_i (first-word fall-through)
- fifo_rx_empty_i  in  1  PHY receive FIFO empty
- rx_valid_o  out  1  decoded byte valid
- rx_data_o  out  8  decoded byte
- rx_last_o  out  1  last byte of the frame
- rx_err_o  out  1  frame was corrupt; valid only with rx_last_o
- rx_ready_i  in  1  upstream accepts; transfer when rx_valid_o && rx_ready_i
- err_cnt_o  out  8  saturating count of corrupt frames

Behaviour:
Constants: END=0xC0, ESC=0xDB, ESC_END=0xDC, ESC_ESC=0xDD.

Reset:
- Encoder state is TX_START if LEADEND, else TX_DATA.
- Decoder is in RX_DATA with no pending byte and the escape flag clear.
- All outputs are 0, including err_cnt_o.
- Reset mid-frame discards any partial frame on both paths.

Encoder:
- fifo_tx_write_o is registered-free (combinational from state).
- Every write requires !fifo_tx_full_i; a full FIFO stalls the encoder in its current state with no loss.
- TX_START:
  - tx_ready_o=0.
  - When tx_valid_i && !full: write END, go to TX_DATA.
- TX_DATA:
  - tx_ready_o = !fifo_tx_full_i.
  - On accept of 0xC0: write ESC, latch pend=ESC_END and plast=tx_last_i, go to TX_ESC2.
  - On accept of 0xDB: same, with pend=ESC_ESC.
  - On accept of any other byte: write the byte. If tx_last_i, go to TX_END.
- TX_ESC2:
  - tx_ready_o=0.
  - When !full: write pend, then go to TX_END if plast, else TX_DATA.
- TX_END:
  - tx_ready_o=0.
  - When !full: write END, then go to the reset state (TX_START or TX_DATA).
- Throughput is one FIFO write per cycle. Empty frames cannot be sent.

Decoder:
- Output stage is one register: rx_valid_o, rx_data_o, rx_last_o, rx_err_o.
- fifo_rx_read_o = !fifo_rx_empty_i && (!rx_valid_o || rx_ready_i).
- Each popped byte is processed in the pop cycle; results appear on the next edge.
- One byte is held as "pend" so that last can be attached when END arrives. Latency is therefore one source byte plus one cycle.
- Data byte d, no escape active, not dropping:
  - If pend is valid, output pend with last=0.
  - Then pend <= d and len increments.
- ESC: set the escape flag; no output.
- Byte after ESC:
  - ESC_END decodes as 0xC0; ESC_ESC decodes as 0xDB.
  - Anything else, including END, is a bad escape and enters RX_DROP. For END, the frame also terminates.
- END:
  - If pend is valid, output pend with last=1 and err=drop.
  - If drop, err_cnt increments (saturating at 255), even when no byte is output.
  - Then clear pend, len, escape flag and drop.
  - Consecutive ENDs and empty frames produce nothing.
- Overflow: a data byte arriving when len==MAXLEN enters RX_DROP.
- RX_DROP:
  - Bytes are discarded until END.
  - pend is retained so the frame is closed with last=1, err=1.
- When rx_valid_o && !rx_ready_i, no pop occurs and the output holds stable.

Test Plan:
1. Encoder, LEADEND=1, frame {0x01, 0xC0, 0xDB, 0x02 last}, FIFO never full:
   - FIFO receives C0 01 DB DC DB DD 02 C0 on 8 consecutive writes.
   - tx_ready_o is low during the escape and END cycles.
2. Encoder backpressure: hold fifo_tx_full_i=1 for 5 cycles mid-frame:
   - No writes and no accepts during the stall.
   - Byte sequence is identical to scenario 1.
3. Decoder, FIFO holds C0 C0 41 DB DC 42 C0, rx_ready_i=1:
   - Outputs 41/last0, C0/last0, 42/last1/err0.
   - err_cnt_o stays 0.
4. Decoder with bad escape, input 10 DB 55 20 C0:
   - Single output 10/last1/err1.
   - err_cnt_o becomes 1.
5. Decoder, MAXLEN=4, 6-byte frame 1..6 then C0:
   - Outputs 1, 2, 3 with last0, then 4/last1/err1.
   - err_cnt_o increments.
6. Reset and backpressure:
   - rx_ready_i low for 10 cycles: fifo_rx_read_o stays 0 and the output holds.
   - rst_i asserted mid-frame on both paths: all outputs are 0 immediately. The next clean frame decodes correctly.

Source files
------------

// File: rtl/usb_serial_slip_if.sv
// SLIP codec bus bundle: user tx stream, PHY tx/rx FIFO user ports, user rx stream.
// Latency: none (wires only).
// Backpressure: carries valid/ready on the user side and full/empty on the FIFO side.
interface usb_serial_slip_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_last_i;
  logic       tx_ready_o;
  logic       fifo_tx_write_o;
  logic [7:0] fifo_tx_data_o;
  logic       fifo_tx_full_i;
  logic       fifo_rx_read_o;
  logic [7:0] fifo_rx_data_i;
  logic       fifo_rx_empty_i;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_last_o;
  logic       rx_err_o;
  logic       rx_ready_i;
  logic [7:0] err_cnt_o;

  // codec side
  modport slave (
    input  tx_valid_i, tx_data_i, tx_last_i, fifo_tx_full_i,
    input  fifo_rx_data_i, fifo_rx_empty_i, rx_ready_i,
    output tx_ready_o, fifo_tx_write_o, fifo_tx_data_o, fifo_rx_read_o,
    output rx_valid_o, rx_data_o, rx_last_o, rx_err_o, err_cnt_o
  );

  // user + PHY side
  modport master (
    output tx_valid_i, tx_data_i, tx_last_i, fifo_tx_full_i,
    output fifo_rx_data_i, fifo_rx_empty_i, rx_ready_i,
    input  tx_ready_o, fifo_tx_write_o, fifo_tx_data_o, fifo_rx_read_o,
    input  rx_valid_o, rx_data_o, rx_last_o, rx_err_o, err_cnt_o
  );
endinterface

// File: rtl/usb_serial_slip.sv
// SLIP framing codec between user byte streams and the USB serial FIFO-PHY.
// Latency: encoder writes in the accept cycle; decoder output lags by one source byte plus one cycle.
// Backpressure: full FIFO stalls the encoder in place; held rx output stops FIFO pops.
module usb_serial_slip #(
  parameter int MAXLEN  = 256,
  parameter int LEADEND = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  usb_serial_slip_if.slave bus
);

  localparam logic [7:0] END     = 8'hC0;
  localparam logic [7:0] ESC     = 8'hDB;
  localparam logic [7:0] ESC_END = 8'hDC;
  localparam logic [7:0] ESC_ESC = 8'hDD;
  localparam int         LW      = $clog2(MAXLEN) + 1;

  typedef enum logic [1:0] {TX_START, TX_DATA, TX_ESC2, TX_END} tx_state_t;
  typedef enum logic       {RX_DATA, RX_DROP} rx_state_t;

  localparam tx_state_t TX_IDLE = (LEADEND != 0) ? TX_START : TX_DATA;

  // ---------------- encoder ----------------
  tx_state_t  tx_state;
  logic [7:0] tx_pend;
  logic       tx_plast;
  logic       tx_wr;
  logic [7:0] tx_byte;
  logic       tx_rdy;
  logic       tx_is_special;

  assign tx_is_special = (bus.tx_data_i == END) || (bus.tx_data_i == ESC);

  // Encoder state walk; nothing moves while the PHY FIFO is full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_pend  <= 8'h00;
      tx_plast <= 1'b0;
    end else if (!bus.fifo_tx_full_i) begin
      case (tx_state)
        TX_START: if (bus.tx_valid_i) tx_state <= TX_DATA;
        TX_DATA: begin
          if (bus.tx_valid_i) begin
            if (tx_is_special) begin
              tx_pend  <= (bus.tx_data_i == END) ? ESC_END : ESC_ESC;
              tx_plast <= bus.tx_last_i;
              tx_state <= TX_ESC2;
            end else if (bus.tx_last_i) begin
              tx_state <= TX_END;
            end
          end
        end
        TX_ESC2: tx_state <= tx_plast ? TX_END : TX_DATA;
        TX_END:  tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // FIFO write strobe, byte and user ready decoded straight from state.
  always_comb begin
    tx_wr   = 1'b0;
    tx_byte = 8'h00;
    tx_rdy  = 1'b0;
    if (!rst_i && !bus.fifo_tx_full_i) begin
      case (tx_state)
        TX_START: begin tx_wr = bus.tx_valid_i; tx_byte = END; end
        TX_DATA: begin
          tx_rdy  = 1'b1;
          tx_wr   = bus.tx_valid_i;
          tx_byte = tx_is_special ? ESC : bus.tx_data_i;
        end
        TX_ESC2: begin tx_wr = 1'b1; tx_byte = tx_pend; end
        TX_END:  begin tx_wr = 1'b1; tx_byte = END; end
        default: tx_wr = 1'b0;
      endcase
    end
    if (!tx_wr) tx_byte = 8'h00;
  end

  assign bus.tx_ready_o      = tx_rdy;
  assign bus.fifo_tx_write_o = tx_wr;
  assign bus.fifo_tx_data_o  = tx_byte;

  // ---------------- decoder ----------------
  rx_state_t   rx_state;
  logic          esc_q;
  logic [7:0]    pend_q;
  logic          pend_vld_q;
  logic [LW-1:0] len_q;
  logic          rx_vld_q, rx_last_q, rx_err_q;
  logic [7:0]    rx_dat_q;
  logic [7:0]    err_cnt_q;
  logic          rx_rd;
  logic          dec_end, dec_err, dec_dat, dec_bad, dec_esc, dec_ovf;
  logic [7:0]    dec_byte;

  assign rx_rd = !rst_i && !bus.fifo_rx_empty_i && (!rx_vld_q || bus.rx_ready_i);

  // Classify the FIFO head byte against the escape/drop context.
  always_comb begin
    dec_end  = 1'b0;
    dec_err  = 1'b0;
    dec_dat  = 1'b0;
    dec_bad  = 1'b0;
    dec_esc  = 1'b0;
    dec_byte = bus.fifo_rx_data_i;
    if (rx_state == RX_DROP) begin
      if (bus.fifo_rx_data_i == END) begin dec_end = 1'b1; dec_err = 1'b1; end
    end else if (esc_q) begin
      case (bus.fifo_rx_data_i)
        ESC_END: begin dec_dat = 1'b1; dec_byte = END; end
        ESC_ESC: begin dec_dat = 1'b1; dec_byte = ESC; end
        END:     begin dec_end = 1'b1; dec_err = 1'b1; end
        default: dec_bad = 1'b1;
      endcase
    end else begin
      case (bus.fifo_rx_data_i)
        END:     dec_end = 1'b1;
        ESC:     dec_esc = 1'b1;
        default: dec_dat = 1'b1;
      endcase
    end
    dec_ovf = dec_dat && (len_q == LW'(MAXLEN));
  end

  // Pop/decode one byte per cycle; one byte is held back so END can tag it last.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state   <= RX_DATA;
      esc_q      <= 1'b0;
      pend_q     <= 8'h00;
      pend_vld_q <= 1'b0;
      len_q      <= '0;
      rx_vld_q   <= 1'b0;
      rx_dat_q   <= 8'h00;
      rx_last_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      if (rx_vld_q && bus.rx_ready_i) rx_vld_q <= 1'b0;
      if (rx_rd) begin
        if (dec_end) begin
          if (pend_vld_q) begin
            rx_vld_q  <= 1'b1;
            rx_dat_q  <= pend_q;
            rx_last_q <= 1'b1;
            rx_err_q  <= dec_err;
          end
          if (dec_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          pend_vld_q <= 1'b0;
          len_q      <= '0;
          esc_q      <= 1'b0;
          rx_state   <= RX_DATA;
        end else if (dec_bad || dec_ovf) begin
          esc_q    <= 1'b0;
          rx_state <= RX_DROP;
        end else if (dec_esc) begin
          esc_q <= 1'b1;
        end else if (dec_dat) begin
          esc_q <= 1'b0;
          if (pend_vld_q) begin
            rx_vld_q  <= 1'b1;
            rx_dat_q  <= pend_q;
            rx_last_q <= 1'b0;
            rx_err_q  <= 1'b0;
          end
          pend_q     <= dec_byte;
          pend_vld_q <= 1'b1;
          len_q      <= len_q + LW'(1);
        end
      end
    end
  end

  assign bus.fifo_rx_read_o = rx_rd;
  assign bus.rx_valid_o     = rx_vld_q;
  assign bus.rx_data_o      = rx_dat_q;
  assign bus.rx_last_o      = rx_last_q;
  assign bus.rx_err_o       = rx_err_q;
  assign bus.err_cnt_o      = err_cnt_q;

endmodule
